// File: rtl/cv32e40p_if_id_queue_pkg.sv
// cv32e40p_if_id_queue_pkg: entry type and pointer helper shared by the IF->ID queue.
package cv32e40p_if_id_queue_pkg;
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        compressed;
      logic        illegal_c;
      logic        fetch_failed;
   } if_entry_t;

   function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
      return (p == depth - 1) ? 0 : p + 1;
   endfunction
endpackage

// File: rtl/cv32e40p_if_id_queue_if.sv
// cv32e40p_if_id_queue_if: IF-side push and ID-side pop handshakes of the IF->ID queue.
interface cv32e40p_if_id_queue_if;
   import cv32e40p_if_id_queue_pkg::*;
   logic      in_valid;
   logic      in_ready;
   if_entry_t in_entry;
   logic      out_valid;
   logic      out_ready;
   if_entry_t out_entry;
   modport master (output in_valid, in_entry, out_ready, input in_ready, out_valid, out_entry);
   modport slave (input in_valid, in_entry, out_ready, output in_ready, out_valid, out_entry);
endinterface

// File: rtl/cv32e40p_if_id_queue.sv
// cv32e40p_if_id_queue: DEPTH-entry IF->ID decoupling FIFO with flush, forced reset and drop modes.
module cv32e40p_if_id_queue
   import cv32e40p_if_id_queue_pkg::*;
#(
   parameter int unsigned DEPTH        = 2,
   parameter bit          FULL_PUSHPOP = 1'b1,
   localparam int unsigned CNT_W       = $clog2(DEPTH + 1),
   localparam int unsigned PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    force_reset,
   input  logic                    force_invalid,
   cv32e40p_if_id_queue_if.slave   bus,
   output logic [CNT_W-1:0]        level,
   output logic                    overflow
);
   if_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] count;
   logic             full, push, pop, write;

   assign full          = count == CNT_W'(DEPTH);
   assign bus.in_ready  = !full || (FULL_PUSHPOP && bus.out_ready);
   assign bus.out_valid = count != '0;
   assign bus.out_entry = mem[rd_ptr];
   assign push          = bus.in_valid && bus.in_ready;
   assign pop           = bus.out_valid && bus.out_ready;
   assign write         = push && !force_invalid;
   assign level         = count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         mem      <= '{default: '0};
      end else begin
         if (bus.in_valid && !bus.in_ready && !flush) overflow <= 1'b1;
         if (force_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            mem    <= '{default: '0};
         end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            // when full with a concurrent pop, wr_ptr == rd_ptr so the freed head slot is reused
            if (write) begin
               mem[wr_ptr] <= bus.in_entry;
               wr_ptr      <= PTR_W'(wrap_inc(int'(wr_ptr), DEPTH));
            end
            if (pop) rd_ptr <= PTR_W'(wrap_inc(int'(rd_ptr), DEPTH));
            count <= count + CNT_W'(write) - CNT_W'(pop);
         end
      end
   end
endmodule

// File: tb/tb_cv32e40p_if_id_queue.sv
// tb_cv32e40p_if_id_queue: directed checks on DEPTH=2 (both FULL_PUSHPOP modes) and DEPTH=3 queues.
module tb_cv32e40p_if_id_queue;
   import cv32e40p_if_id_queue_pkg::*;
   logic      clk = 1'b0;
   logic      rst_n = 1'b0;
   logic      flush = 1'b0, force_reset = 1'b0, force_invalid = 1'b0;
   logic      in_valid = 1'b0, out_ready = 1'b0;
   if_entry_t in_entry = '0;
   logic [1:0] lvl2, lvl2n, lvl3;
   logic       ovf2, ovf2n, ovf3;
   int         errors = 0, checks = 0;

   always #5 clk = ~clk;

   cv32e40p_if_id_queue_if b2 ();
   cv32e40p_if_id_queue_if b2n ();
   cv32e40p_if_id_queue_if b3 ();
   assign b2.in_valid  = in_valid;
   assign b2.in_entry  = in_entry;
   assign b2.out_ready = out_ready;
   assign b2n.in_valid  = in_valid;
   assign b2n.in_entry  = in_entry;
   assign b2n.out_ready = out_ready;
   assign b3.in_valid  = in_valid;
   assign b3.in_entry  = in_entry;
   assign b3.out_ready = out_ready;

   cv32e40p_if_id_queue #(.DEPTH(2), .FULL_PUSHPOP(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .flush(flush),
      .force_reset(force_reset), .force_invalid(force_invalid), .bus(b2.slave), .level(lvl2), .overflow(ovf2));
   cv32e40p_if_id_queue #(.DEPTH(2), .FULL_PUSHPOP(1'b0)) u2n (.clk(clk), .rst_n(rst_n), .flush(flush),
      .force_reset(force_reset), .force_invalid(force_invalid), .bus(b2n.slave), .level(lvl2n), .overflow(ovf2n));
   cv32e40p_if_id_queue #(.DEPTH(3), .FULL_PUSHPOP(1'b1)) u3 (.clk(clk), .rst_n(rst_n), .flush(flush),
      .force_reset(force_reset), .force_invalid(force_invalid), .bus(b3.slave), .level(lvl3), .overflow(ovf3));

   function automatic if_entry_t ent(input logic [31:0] instr, input logic [31:0] pc);
      return '{instr: instr, pc: pc, compressed: pc[2], illegal_c: 1'b0, fetch_failed: instr[0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if ({b2.out_valid, lvl2, ovf2} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_state got valid/level/ovf=%b want 0000", {b2.out_valid, lvl2, ovf2});
      end
      checks++;
      if (b2.out_entry !== '0) begin
         errors++;
         $display("FAIL reset_entry got=%h want=0", b2.out_entry);
      end
      checks++;
      if (b2.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got=%b want=1", b2.in_ready);
      end
   endtask

   task automatic test_fill();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_entry  = ent(32'h11, 32'h100);
      step();
      checks++;
      if ({b2.out_valid, lvl2} !== 3'b101 || b2.out_entry.pc !== 32'h100) begin
         errors++;
         $display("FAIL fill_one got valid=%b level=%0d pc=%h want 1 1 00000100", b2.out_valid, lvl2, b2.out_entry.pc);
      end
      in_entry = ent(32'h22, 32'h104);
      step();
      in_valid = 1'b0;
      #1;
      checks++;
      if (lvl2 !== 2'd2 || b2.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL fill_full got level=%0d ready=%b want 2 0", lvl2, b2.in_ready);
      end
      checks++;
      if (b2.out_entry !== ent(32'h11, 32'h100)) begin
         errors++;
         $display("FAIL fill_head got=%h want=%h", b2.out_entry, ent(32'h11, 32'h100));
      end
      checks++;
      if (lvl2n !== 2'd2) begin
         errors++;
         $display("FAIL fill_nopp_level got=%0d want=2", lvl2n);
      end
   endtask

   task automatic test_pushpop_full();
      in_valid  = 1'b1;
      in_entry  = ent(32'h33, 32'h108);
      out_ready = 1'b1;
      #1;
      checks++;
      if ({b2.in_ready, b2n.in_ready} !== 2'b10) begin
         errors++;
         $display("FAIL pp_ready got pp1=%b pp0=%b want 1 0", b2.in_ready, b2n.in_ready);
      end
      step();
      in_valid = 1'b0;
      checks++;
      if (lvl2 !== 2'd2 || b2.out_entry.pc !== 32'h104) begin
         errors++;
         $display("FAIL pp_after1 got level=%0d pc=%h want 2 00000104", lvl2, b2.out_entry.pc);
      end
      checks++;
      if (lvl2n !== 2'd1 || b2n.out_entry.pc !== 32'h104 || ovf2n !== 1'b1 || ovf2 !== 1'b0) begin
         errors++;
         $display("FAIL pp_nopp got level=%0d pc=%h ovf0=%b ovf1=%b want 1 00000104 1 0", lvl2n, b2n.out_entry.pc, ovf2n, ovf2);
      end
      step();
      checks++;
      if (lvl2 !== 2'd1 || b2.out_entry !== ent(32'h33, 32'h108)) begin
         errors++;
         $display("FAIL pp_c got level=%0d entry=%h want 1 %h", lvl2, b2.out_entry, ent(32'h33, 32'h108));
      end
      checks++;
      if ({b2n.out_valid, lvl2n} !== 3'b000) begin
         errors++;
         $display("FAIL pp_nopp_drained got valid=%b level=%0d want 0 0", b2n.out_valid, lvl2n);
      end
      step();
      out_ready = 1'b0;
      checks++;
      if ({b2.out_valid, lvl2} !== 3'b000) begin
         errors++;
         $display("FAIL pp_drained got valid=%b level=%0d want 0 0", b2.out_valid, lvl2);
      end
   endtask

   task automatic test_flush();
      in_valid = 1'b1;
      in_entry = ent(32'h11, 32'h100);
      step();
      in_entry = ent(32'h22, 32'h104);
      step();
      flush     = 1'b1;
      in_entry  = ent(32'h33, 32'h108);
      out_ready = 1'b1;
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++;
      if ({b2.out_valid, lvl2, ovf2} !== 4'b0000) begin
         errors++;
         $display("FAIL flush_state got valid/level/ovf=%b want 0000", {b2.out_valid, lvl2, ovf2});
      end
      in_valid = 1'b1;
      in_entry = ent(32'h44, 32'h10c);
      step();
      in_valid = 1'b0;
      checks++;
      if (lvl2 !== 2'd1 || b2.out_entry.pc !== 32'h10c) begin
         errors++;
         $display("FAIL flush_c_lost got level=%0d pc=%h want 1 0000010c", lvl2, b2.out_entry.pc);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_force_invalid();
      force_invalid = 1'b1;
      in_valid      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_entry = ent(32'h50 + i, 32'h400 + 4 * i);
         #1;
         checks++;
         if (b2.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL finv_ready[%0d] got=%b want=1", i, b2.in_ready);
         end
         step();
         checks++;
         if ({b2.out_valid, lvl2} !== 3'b000) begin
            errors++;
            $display("FAIL finv_level[%0d] got valid=%b level=%0d want 0 0", i, b2.out_valid, lvl2);
         end
      end
      force_invalid = 1'b0;
      in_valid      = 1'b0;
   endtask

   task automatic test_force_reset();
      in_valid = 1'b1;
      in_entry = ent(32'hdeadbeef, 32'h200);
      step();
      in_valid = 1'b0;
      checks++;
      if (b2.out_entry.instr !== 32'hdeadbeef) begin
         errors++;
         $display("FAIL frst_pre got=%h want=deadbeef", b2.out_entry.instr);
      end
      force_reset = 1'b1;
      step();
      force_reset = 1'b0;
      checks++;
      if (b2.out_entry !== '0 || {b2.out_valid, lvl2} !== 3'b000) begin
         errors++;
         $display("FAIL frst_zero got entry=%h valid=%b level=%0d want 0 0 0", b2.out_entry, b2.out_valid, lvl2);
      end
   endtask

   task automatic test_mid_reset();
      in_valid = 1'b1;
      in_entry = ent(32'h66, 32'h300);
      step();
      in_valid = 1'b0;
      checks++;
      if (lvl2 !== 2'd1 || ovf2n !== 1'b1) begin
         errors++;
         $display("FAIL mrst_pre got level=%0d ovf=%b want 1 1", lvl2, ovf2n);
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if ({b2.out_valid, lvl2, ovf2} !== 4'b0000 || b2.out_entry !== '0) begin
         errors++;
         $display("FAIL mrst_state got valid/level/ovf=%b entry=%h want 0000 0", {b2.out_valid, lvl2, ovf2}, b2.out_entry);
      end
      checks++;
      if (ovf2n !== 1'b0) begin
         errors++;
         $display("FAIL mrst_ovf got=%b want=0", ovf2n);
      end
   endtask

   task automatic test_wrap_depth3();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_entry = ent(32'h1000 + i, 32'h500 + 4 * i);
         step();
         checks++;
         if (lvl3 !== 2'd1 || b3.out_entry !== ent(32'h1000 + i, 32'h500 + 4 * i)) begin
            errors++;
            $display("FAIL wrap[%0d] got level=%0d entry=%h want 1 %h", i, lvl3, b3.out_entry, ent(32'h1000 + i, 32'h500 + 4 * i));
         end
      end
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_entry = ent(32'h2000 + i, 32'h600 + 4 * i);
         step();
      end
      in_valid = 1'b0;
      #1;
      checks++;
      if (lvl3 !== 2'd3 || b3.in_ready !== 1'b0 || b3.out_entry.pc !== 32'h518) begin
         errors++;
         $display("FAIL wrap_full got level=%0d ready=%b pc=%h want 3 0 00000518", lvl3, b3.in_ready, b3.out_entry.pc);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (i < 2 && b3.out_entry.pc !== 32'h600 + 4 * i) begin
            errors++;
            $display("FAIL wrap_drain[%0d] got pc=%h want %h", i, b3.out_entry.pc, 32'h600 + 4 * i);
         end else if (i == 2 && {b3.out_valid, lvl3} !== 3'b000) begin
            errors++;
            $display("FAIL wrap_empty got valid=%b level=%0d want 0 0", b3.out_valid, lvl3);
         end
      end
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_pushpop_full();
      test_flush();
      test_force_invalid();
      test_force_reset();
      test_mid_reset();
      test_wrap_depth3();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
